water_level_sampler: RTL and testbench

WATER_LEVEL_SAMPLER -- requirements
Module: water_level_sampler

---
 rtl/water_level_sampler.sv | 92 +++++++++
 tb/tb_water_level_sampler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/water_level_sampler.sv
// water_level_sampler: debounced/auto-triggered sampling of saturated channel levels
// with per-channel hysteresis alarms and a sample counter.
module water_level_sampler #(
    parameter int CH          = 2,
    parameter int W           = 4,
    parameter int MAX_LEVEL   = 14,
    parameter int DB_CYCLES   = 20,
    parameter int AUTO_PERIOD = 1000,
    parameter int HI_SET      = 12,
    parameter int HI_CLR      = 10,
    parameter int LO_SET      = 3,
    parameter int LO_CLR      = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*W-1:0] level_in,
    input  logic            btn0,
    input  logic            mode,
    output logic [CH*W-1:0] level_out,
    output logic            sample_valid,
    output logic [CH-1:0]   alarm_hi,
    output logic [CH-1:0]   alarm_lo,
    output logic [7:0]      sample_cnt
);
    localparam int DBW = $clog2(DB_CYCLES);
    localparam int TW  = $clog2(AUTO_PERIOD);

    logic            sync1_q, sync_q;
    logic            b_q, b_d, b_dly_q, press_q, db_hit;
    logic [DBW-1:0]  db_cnt_q, db_cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            tick, req;
    logic [CH*W-1:0] lvl_q, lvl_d;
    logic            valid_q;
    logic [7:0]      cnt_q;
    logic [CH-1:0]   hi_q, hi_d, lo_q, lo_d;

    always_comb begin
        db_hit   = db_cnt_q == DBW'(DB_CYCLES - 1);
        b_d      = (sync_q != b_q && db_hit) ? sync_q : b_q;
        db_cnt_d = (sync_q == b_q || db_hit) ? '0 : db_cnt_q + DBW'(1);
        tick     = mode && tmr_q == TW'(AUTO_PERIOD - 1);
        tmr_d    = (!mode || tick) ? '0 : tmr_q + TW'(1);
        req      = press_q | tick;
    end

    // Alarms look at the already-latched level, so they trail sample_valid by one cycle.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [W-1:0] raw, cur;
        assign raw = level_in[i*W +: W];
        assign cur = lvl_q[i*W +: W];
        assign lvl_d[i*W +: W] = req ? ((raw > W'(MAX_LEVEL)) ? W'(MAX_LEVEL) : raw) : cur;
        assign hi_d[i] = !valid_q ? hi_q[i] : (cur >= W'(HI_SET)) ? 1'b1 : (cur <= W'(HI_CLR)) ? 1'b0 : hi_q[i];
        assign lo_d[i] = !valid_q ? lo_q[i] : (cur <= W'(LO_SET)) ? 1'b1 : (cur >= W'(LO_CLR)) ? 1'b0 : lo_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            b_q      <= 1'b0;
            b_dly_q  <= 1'b0;
            press_q  <= 1'b0;
            db_cnt_q <= '0;
            tmr_q    <= '0;
            lvl_q    <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            sync1_q  <= btn0;
            sync_q   <= sync1_q;
            b_q      <= b_d;
            b_dly_q  <= b_q;
            press_q  <= b_q & ~b_dly_q;
            db_cnt_q <= db_cnt_d;
            tmr_q    <= tmr_d;
            lvl_q    <= lvl_d;
            valid_q  <= req;
            cnt_q    <= req ? cnt_q + 8'd1 : cnt_q;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign level_out    = lvl_q;
    assign sample_valid = valid_q;
    assign sample_cnt   = cnt_q;
    assign alarm_hi     = hi_q;
    assign alarm_lo     = lo_q;
endmodule

// File: tb/tb_water_level_sampler.sv
// tb_water_level_sampler: directed vectors for water_level_sampler with default parameters.
module tb_water_level_sampler;
    logic       clk = 1'b0;
    logic       rst, btn0, mode;
    logic [7:0] level_in, level_out, sample_cnt;
    logic       sample_valid;
    logic [1:0] alarm_hi, alarm_lo;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int nsv    = 0;
    int pq[$];
    int base, c0, q0;

    water_level_sampler dut (
        .clk(clk), .rst(rst), .level_in(level_in), .btn0(btn0), .mode(mode),
        .level_out(level_out), .sample_valid(sample_valid),
        .alarm_hi(alarm_hi), .alarm_lo(alarm_lo), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (sample_valid) begin
        nsv <= nsv + 1;
        pq.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press();
        btn0 = 1'b1;
        tick(30);
        btn0 = 1'b0;
        tick(30);
    endtask

    initial begin
        rst = 1'b1; btn0 = 1'b0; mode = 1'b0; level_in = 8'h00;
        tick(3);
        chk("rst_level", level_out, 8'h00);
        chk("rst_valid", sample_valid, 1'b0);
        chk("rst_cnt", sample_cnt, 8'd0);
        chk("rst_hi", alarm_hi, 2'b00);
        chk("rst_lo", alarm_lo, 2'b00);
        rst = 1'b0;
        tick(2);

        // clean press, latency and alarm timing
        level_in = 8'h27;
        btn0 = 1'b1;
        tick(23);
        chk("lat_early", sample_valid, 1'b0);
        tick(1);
        chk("lat_valid", sample_valid, 1'b1);
        chk("p1_level", level_out, 8'h27);
        chk("p1_cnt", sample_cnt, 8'd1);
        chk("p1_lo_late", alarm_lo, 2'b00);
        tick(1);
        chk("p1_pulse", sample_valid, 1'b0);
        chk("p1_lo", alarm_lo, 2'b10);
        chk("p1_hi", alarm_hi, 2'b00);
        tick(15);
        btn0 = 1'b0;
        level_in = 8'hFF;
        tick(60);
        chk("p1_nsv", nsv, 1);
        chk("hold_level", level_out, 8'h27);

        // bounce shorter than debounce window
        base = nsv;
        for (int i = 0; i < 40; i++) begin
            btn0 = ~btn0;
            tick(5);
        end
        tick(40);
        chk("bounce_nsv", nsv, base);
        chk("bounce_level", level_out, 8'h27);

        // saturation and high-alarm hysteresis on ch0
        level_in = 8'h8F;
        press();
        chk("s15_level", level_out, 8'h8E);
        chk("s15_hi", alarm_hi, 2'b01);
        chk("s15_lo", alarm_lo, 2'b00);
        level_in = 8'h8B;
        press();
        chk("s11_level", level_out, 8'h8B);
        chk("s11_hi", alarm_hi, 2'b01);
        level_in = 8'h89;
        press();
        chk("s9_level", level_out, 8'h89);
        chk("s9_hi", alarm_hi, 2'b00);
        chk("s9_cnt", sample_cnt, 8'd4);

        // reset mid-debounce with alarms set
        level_in = 8'h1D;
        press();
        chk("pre_rst_hi", alarm_hi, 2'b01);
        chk("pre_rst_lo", alarm_lo, 2'b10);
        chk("pre_rst_cnt", sample_cnt, 8'd5);
        btn0 = 1'b1;
        tick(17);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_level", level_out, 8'h00);
        chk("mid_rst_cnt", sample_cnt, 8'd0);
        chk("mid_rst_hi", alarm_hi, 2'b00);
        chk("mid_rst_lo", alarm_lo, 2'b00);
        chk("mid_rst_valid", sample_valid, 1'b0);
        base = nsv;
        tick(23);
        chk("post_rst_nsv", nsv, base);
        tick(1);
        chk("post_rst_valid", sample_valid, 1'b1);
        chk("post_rst_cnt", sample_cnt, 8'd1);
        chk("post_rst_level", level_out, 8'h1D);
        btn0 = 1'b0;
        tick(30);

        // auto mode: three ticks 1000 cycles apart
        q0 = pq.size();
        mode = 1'b1;
        c0 = cyc;
        tick(3005);
        chk("auto_n", pq.size() - q0, 3);
        if (pq.size() - q0 == 3) begin
            chk("auto_first", pq[q0] - c0, 1000);
            chk("auto_gap1", pq[q0+1] - pq[q0], 1000);
            chk("auto_gap2", pq[q0+2] - pq[q0+1], 1000);
        end
        chk("auto_cnt", sample_cnt, 8'd4);

        // press event landing on the same cycle as the auto tick
        tick(c0 + 3976 - cyc);
        base = nsv;
        btn0 = 1'b1;
        tick(24);
        chk("coin_valid", sample_valid, 1'b1);
        chk("coin_cnt", sample_cnt, 8'd5);
        tick(1);
        chk("coin_pulse", sample_valid, 1'b0);
        tick(20);
        chk("coin_nsv", nsv - base, 1);
        chk("coin_cnt_end", sample_cnt, 8'd5);
        btn0 = 1'b0;
        mode = 1'b0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
